// File: rtl/pwm_pkg.sv
// pwm_pkg: command codes, FSM encoding and control-bit positions shared by the PWM output stage.
// Revision 1.0
`default_nettype none

package pwm_pkg;

    localparam logic [1:0] CMD_DUTY  = 2'b00;
    localparam logic [1:0] CMD_PER   = 2'b01;
    localparam logic [1:0] CMD_PRESC = 2'b10;
    localparam logic [1:0] CMD_CTRL  = 2'b11;

    localparam int EN_BIT  = 0;
    localparam int INV_BIT = 1;

    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: counts 0..presc and flags the terminal count as the PWM count tick.
// Revision 1.0
`default_nettype none

module pwm_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clear,
    output logic               tick
);

    logic [PRESC_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
        end else if (clear || (r_pc == presc)) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign tick = (r_pc == presc);

endmodule

`default_nettype wire

// File: rtl/pwm_saida.sv
// pwm_saida: PWM output stage with shadowed duty/period, applied only at period boundaries.
// Revision 1.0
`default_nettype none

module pwm_saida
    import pwm_pkg::*;
#(
    parameter int LARGURA = 16,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        controlePWM,
    input  logic [31:0] toOUT,
    output logic        pwm,
    output logic        fim_periodo,
    output logic        pendente,
    output logic        ativo
);

    logic [1:0]         w_cmd;
    logic               w_wr_duty;
    logic               w_wr_per;
    logic               w_wr_presc;
    logic               w_wr_ctrl;
    logic               w_tick;
    logic               w_clear;
    logic               w_wrap;
    logic               w_unused_bits;

    logic [LARGURA-1:0] r_duty_sh;
    logic [LARGURA-1:0] r_per_sh;
    logic [LARGURA-1:0] r_duty_at;
    logic [LARGURA-1:0] r_per_at;
    logic [LARGURA-1:0] r_cnt;
    logic [PRESC_W-1:0] r_presc;
    logic               r_en;
    logic               r_inv;
    logic               r_pwm;
    logic               r_fim;
    logic               r_pend;

    estado_t            r_estado;
    estado_t            w_prox_estado;

    assign w_cmd      = toOUT[31:30];
    assign w_wr_duty  = controlePWM && (w_cmd == CMD_DUTY);
    assign w_wr_per   = controlePWM && (w_cmd == CMD_PER);
    assign w_wr_presc = controlePWM && (w_cmd == CMD_PRESC);
    assign w_wr_ctrl  = controlePWM && (w_cmd == CMD_CTRL);

    assign w_unused_bits = ^toOUT[29:LARGURA];

    // Prescaler is parked at 0 while idle and restarts on every divisor write.
    assign w_clear = (r_estado == ST_OFF) || w_wr_presc;
    assign w_wrap  = (r_estado == ST_RUN) && w_tick && (r_cnt == r_per_at);

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .presc (r_presc),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty_sh <= '0;
            r_per_sh  <= '0;
            r_presc   <= '0;
            r_en      <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            if (w_wr_duty)  r_duty_sh <= toOUT[LARGURA-1:0];
            if (w_wr_per)   r_per_sh  <= toOUT[LARGURA-1:0];
            if (w_wr_presc) r_presc   <= toOUT[PRESC_W-1:0];
            if (w_wr_ctrl) begin
                r_en  <= toOUT[EN_BIT];
                r_inv <= toOUT[INV_BIT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado <= ST_OFF;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            ST_OFF:  if (r_en)  w_prox_estado = ST_RUN;
            ST_RUN:  if (!r_en) w_prox_estado = ST_OFF;
            default: w_prox_estado = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_duty_at <= '0;
            r_per_at  <= '0;
            r_pwm     <= 1'b0;
            r_fim     <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            if (r_estado == ST_OFF) begin
                r_cnt     <= '0;
                r_duty_at <= r_duty_sh;
                r_per_at  <= r_per_sh;
                r_pend    <= 1'b0;
                r_pwm     <= r_inv;
            end else begin
                r_pwm <= (r_cnt < r_duty_at) ^ r_inv;
                if (w_wrap) begin
                    r_cnt     <= '0;
                    r_duty_at <= r_duty_sh;
                    r_per_at  <= r_per_sh;
                    r_fim     <= 1'b1;
                end else if (w_tick) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // A write landing on the wrap edge misses this update and stays pending.
                if (w_wr_duty || w_wr_per) begin
                    r_pend <= 1'b1;
                end else if (w_wrap) begin
                    r_pend <= 1'b0;
                end
            end
        end
    end

    assign pwm         = r_pwm;
    assign fim_periodo = r_fim;
    assign pendente    = r_pend;
    assign ativo       = (r_estado == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pwm_saida.sv
// tb_pwm_saida: directed stimulus; per-period (length, high count) records checked by a monitor.
// Revision 1.0
`default_nettype none

module tb_pwm_saida;
    import pwm_pkg::*;

    typedef struct {
        int len;
        int hi;
    } per_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        controlePWM = 1'b0;
    logic [31:0] toOUT = '0;
    logic        pwm;
    logic        fim_periodo;
    logic        pendente;
    logic        ativo;

    per_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   win_len = 0;
    int   win_hi = 0;
    bit   skip = 1'b1;

    pwm_saida #(
        .LARGURA (16),
        .PRESC_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .controlePWM (controlePWM),
        .toOUT       (toOUT),
        .pwm         (pwm),
        .fim_periodo (fim_periodo),
        .pendente    (pendente),
        .ativo       (ativo)
    );

    always #5 clk = ~clk;

    // Each fim_periodo closes a window of pwm samples; the first RUN sample still shows idle level.
    always @(negedge clk) begin
        if (!rst || !ativo) begin
            win_len = 0;
            win_hi  = 0;
            skip    = 1'b1;
        end else if (skip) begin
            skip = 1'b0;
        end else begin
            win_len++;
            if (pwm) win_hi++;
            if (fim_periodo) begin
                if (sb.size() > 0) begin
                    per_t e;
                    e = sb.pop_front();
                    checks++;
                    if (e.len != win_len || e.hi != win_hi) begin
                        errors++;
                        $display("FAIL periodo: got len=%0d hi=%0d expected len=%0d hi=%0d",
                                 win_len, win_hi, e.len, e.hi);
                    end
                end
                win_len = 0;
                win_hi  = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] cmd, input int val);
        controlePWM = 1'b1;
        toOUT = {cmd, 30'(val)};
        @(posedge clk); #1;
        controlePWM = 1'b0;
        toOUT = '0;
    endtask

    task automatic push(input int len, input int hi, input int n);
        per_t e;
        e.len = len;
        e.hi  = hi;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic wait_size(input int k);
        int n = 0;
        while (sb.size() > k && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > k) begin
            checks++;
            errors++;
            $display("FAIL timeout_fila: got %0d pending expected %0d", sb.size(), k);
            sb.delete();
        end
    endtask

    task automatic wait_fim();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!fim_periodo && n < 100);
        if (!fim_periodo) begin
            checks++;
            errors++;
            $display("FAIL timeout_fim: got 0 expected 1");
        end
    endtask

    // Must be called right after a period wrap so the write lands mid-period.
    task automatic muda_duty(input int nd, input int cur_hi, input int new_hi, input int len);
        push(len, cur_hi, 1);
        push(len, new_hi, 2);
        wr(CMD_DUTY, nd);
        chk("pendente_set", 32'(pendente), 1);
        wait_size(2);
        chk("pendente_clr", 32'(pendente), 0);
        wait_size(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_fim", 32'(fim_periodo), 0);
        chk("rst_pend", 32'(pendente), 0);
        chk("rst_ativo", 32'(ativo), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // presc=0, period 10 clk, 3 high
        wr(CMD_DUTY, 3);
        wr(CMD_PER, 9);
        chk("pend_off", 32'(pendente), 0);
        push(10, 3, 3);
        wr(CMD_CTRL, 1);
        wait_size(0);
        chk("ativo_run", 32'(ativo), 1);

        // duty change mid-period
        muda_duty(7, 3, 7, 10);

        // duty write on the exact wrap edge
        wait_fim();
        @(negedge clk); #1;
        push(10, 7, 2);
        push(10, 2, 1);
        repeat (9) @(posedge clk);
        #1;
        controlePWM = 1'b1;
        toOUT = {CMD_DUTY, 30'd2};
        @(posedge clk); #1;
        controlePWM = 1'b0;
        toOUT = '0;
        chk("wrap_fim", 32'(fim_periodo), 1);
        chk("wrap_pend", 32'(pendente), 1);
        @(posedge clk); #1;
        chk("wrap_pend_hold", 32'(pendente), 1);
        wait_size(0);
        chk("wrap_pend_clr", 32'(pendente), 0);

        // prescaler 3, period 5 ticks = 20 clk, duty 2 -> 8 high; then 0 and 10
        wr(CMD_CTRL, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ativo_off", 32'(ativo), 0);
        wr(CMD_PRESC, 3);
        wr(CMD_PER, 4);
        wr(CMD_DUTY, 2);
        push(20, 8, 2);
        wr(CMD_CTRL, 1);
        wait_size(0);
        muda_duty(0, 8, 0, 20);
        muda_duty(10, 0, 20, 20);

        // inverted output: idle high, low 1 / high 4
        wr(CMD_CTRL, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("inv_ativo", 32'(ativo), 0);
        chk("inv_idle", 32'(pwm), 1);
        wr(CMD_PRESC, 0);
        wr(CMD_PER, 4);
        wr(CMD_DUTY, 1);
        push(5, 4, 2);
        wr(CMD_CTRL, 3);
        wait_size(0);
        wr(CMD_CTRL, 2);
        @(posedge clk); #1;
        chk("inv_back_idle", 32'(pwm), 1);
        chk("inv_back_ativo", 32'(ativo), 0);

        // asynchronous reset while running
        wr(CMD_CTRL, 1);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_pwm", 32'(pwm), 0);
        chk("arst_fim", 32'(fim_periodo), 0);
        chk("arst_pend", 32'(pendente), 0);
        chk("arst_ativo", 32'(ativo), 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_pwm", 32'(pwm), 0);
        chk("post_rst_ativo", 32'(ativo), 0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL fila_final: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_saida.md
Name: pwm_saida

Overview:
Downstream PWM output stage of the processor: consumes the 32-bit `toOUT` bus, qualified by the one-cycle `controlePWM` strobe from the control unit, and drives one PWM pin. Configuration writes land in shadow registers. Active duty and period are updated only at a period boundary, so the output never glitches. A prescaler divides the processor clock to a count tick.

Parameters:
- LARGURA, 16, width of the period/duty counter and registers
- PRESC_W, 8, width of the prescaler divisor

Ports:
- clk  in  1  processor (divided) clock, rising edge
- rst  in  1  asynchronous, active-low reset
- controlePWM  in  1  write strobe; `toOUT` is sampled on each clk edge where it is 1
- toOUT  in  32  command word: [31:30] = cmd, payload in low bits
- pwm  out  1  registered PWM output
- fim_periodo  out  1  one-cycle pulse on each period wrap
- pendente  out  1  shadow values written but not yet applied
- ativo  out  1  1 while the FSM is in RUN

Behaviour:
- Commands (cmd = `toOUT[31:30]`):
  - 00: duty_sh <= `toOUT[LARGURA-1:0]`
  - 01: periodo_sh <= `toOUT[LARGURA-1:0]`
  - 10: presc <= `toOUT[PRESC_W-1:0]`; takes effect immediately and restarts the prescaler count
  - 11: en <= `toOUT[0]`, inv <= `toOUT[1]`
  - cmd 00/01 set pendente=1.
- Reset (rst=0, async): all registers 0. Outputs pwm=0, fim_periodo=0, pendente=0, ativo=0. FSM=OFF.
- Tick: prescaler counter pc counts 0..presc. tick=1 when pc==presc, then pc<=0. presc=0 gives tick every cycle.
- FSM states OFF and RUN:
  - OFF -> RUN when en=1. On entry: cnt<=0, pc<=0, duty_at<=duty_sh, periodo_at<=periodo_sh, pendente<=0.
  - RUN -> OFF the cycle after en is seen 0. cnt and pc are held at 0.
  - In OFF, pwm <= inv (idle level), and shadow values are copied to active every cycle (pendente stays 0).
- Counting in RUN:
  - On tick: if cnt==periodo_at then cnt<=0, active<=shadow, pendente<=0, fim_periodo<=1. Else cnt<=cnt+1.
  - Period length is (periodo_at+1)*(presc+1) clocks.
- Output: pwm <= (cnt < duty_at) XOR inv, registered, so 1 cycle latency from cnt.
  - duty_at=0: constant low.
  - duty_at > periodo_at: constant high (before inv).
  - periodo_at=0: period of 1 tick; fim_periodo every tick.
- Simultaneous events:
  - A write in the same cycle as a wrap is not included in that update. The old shadow values are applied, the new value is stored to shadow, and pendente stays/goes 1.
  - Disable in the cycle of a wrap: the wrap still completes (fim_periodo=1), then OFF.
- Reset mid-period: immediate return to reset values. No partial period is output.
- Unsigned arithmetic throughout; cnt wraps only via the compare, never by overflow.

Decomposition:
- Shared package `pwm_pkg` holds:
  - command codes CMD_DUTY=2'b00, CMD_PER=2'b01, CMD_PRESC=2'b10, CMD_CTRL=2'b11
  - FSM state encodings OFF/RUN
  - bit positions EN_BIT=0, INV_BIT=1
- One sub-module, `pwm_prescaler`:
  - inputs: clk, rst, presc, clear
  - output: tick
  - the top level instantiates it once.

Test Plan:
1. Reset while pwm toggling -> all outputs 0 asynchronously; after release, pwm=0 and ativo=0.
2. presc=0, period=9, duty=3, then en=1 -> pwm high 3 clk / low 7 clk repeating; fim_periodo pulses every 10 clk; ativo=1.
3. Running (period=9, duty=3), write duty=7 mid-period -> pendente=1; current period keeps 3-high; the next period is 7-high; pendente clears at the wrap.
4. presc=3, period=4, duty=2 -> period 20 clk with 8 clk high; duty=0 gives constant low; duty=10 gives constant high.
5. Duty write on the exact wrap cycle -> the old duty is used for the next period; the new duty applies one period later; pendente=1 in between.
6. inv=1 with en=0 -> pwm idle high. Then en=1, period=4, duty=1 -> low 1 clk / high 4 clk. Then en=0 -> pwm returns to 1 within 2 clk.
